// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-locking arbiter: rotating-priority grant that stays with the
// winner until its last beat, feeding a single registered output stage.
module rr_packet_arbiter #(
  parameter  int NUM_REQ    = 8,
  parameter  int DATA_WIDTH = 64,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                out_valid_o,
  output logic [DATA_WIDTH-1:0]               out_data_o,
  output logic [IDX_W-1:0]                    out_index_o,
  output logic                                out_last_o,
  input  logic                                out_ready_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] scan_idx;
  logic             cand_vld;
  logic             slot_free;
  logic             xfer;
  int               scan;

  assign slot_free = !out_valid_o || out_ready_i;

  // Candidate selection: the owner while locked, else the first valid requester
  // found scanning upward from ptr with wrap at NUM_REQ.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    scan     = 0;
    scan_idx = '0;
    if (state_q == LOCKED) begin
      cand_vld = 1'b1;
      cand     = owner_q;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        scan = int'(ptr_q) + off;
        if (scan >= NUM_REQ) scan = scan - NUM_REQ;
        scan_idx = IDX_W'(scan);
        if (!cand_vld && req_valid_i[scan_idx]) begin
          cand_vld = 1'b1;
          cand     = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    // NOTE: ready is combinational, so it must be masked by reset explicitly;
    // the output register alone would otherwise report a free slot during reset.
    if (cand_vld && slot_free && !arst_i) req_ready_o[cand] = 1'b1;
  end

  assign xfer = |(req_ready_o & req_valid_i);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      if (req_last_i[cand]) begin
        state_d = IDLE;
        // Explicit wrap keeps ptr inside 0..NUM_REQ-1 for non-power-of-two counts.
        ptr_d   = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = cand;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // A load wins over a drain, so back-to-back beats keep out_valid_o high.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_index_o <= '0;
      out_last_o  <= 1'b0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= req_data_i[cand];
      out_index_o <= cand;
      out_last_o  <= req_last_i[cand];
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter: per-requester source queues drive the
// 8-way instance, a negedge monitor checks every output beat in order.
`timescale 1ns/1ps
module tb_rr_packet_arbiter;

  localparam int N   = 8;
  localparam int DW  = 64;
  localparam int IW  = 3;
  localparam int N5  = 5;
  localparam int DW5 = 8;
  localparam int IW5 = 3;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } src_t;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_last;
  logic [N-1:0]         req_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [IW-1:0]        out_index;
  logic                 out_last;
  logic                 out_ready;

  logic [N5-1:0]          valid5;
  logic [N5-1:0][DW5-1:0] data5;
  logic [N5-1:0]          last5;
  logic [N5-1:0]          ready5;
  logic                   out_valid5;
  logic [DW5-1:0]         out_data5;
  logic [IW5-1:0]         out_index5;
  logic                   out_last5;
  logic                   out_ready5;

  rr_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) u_dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  rr_packet_arbiter #(.NUM_REQ(N5), .DATA_WIDTH(DW5)) u_dut5 (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (valid5),
    .req_data_i  (data5),
    .req_last_i  (last5),
    .req_ready_o (ready5),
    .out_valid_o (out_valid5),
    .out_data_o  (out_data5),
    .out_index_o (out_index5),
    .out_last_o  (out_last5),
    .out_ready_i (out_ready5)
  );

  src_t         src_q [N][$];
  beat_t        exp_q [$];
  beat_t        mon_e;
  logic [N-1:0] pause;
  logic [N-1:0] ready_seen;
  logic [N-1:0] fire_seen;
  logic         out_valid_seen;
  logic [N5-1:0] fire5_seen;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int r, input int b);
    return {8'hD0, 24'(r), 32'(b)};
  endfunction

  task automatic load(input int r, input int nbeats);
    src_t s;
    for (int b = 0; b < nbeats; b++) begin
      s.data = dat(r, b);
      s.last = (b == nbeats - 1);
      src_q[r].push_back(s);
    end
  endtask

  task automatic exp_beat(input int r, input int b, input logic last);
    beat_t e;
    e.idx  = IW'(r);
    e.data = dat(r, b);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (src_q[r].size() > 0 && !pause[r]) begin
        req_valid[r] = 1'b1;
        req_data[r]  = src_q[r][0].data;
        req_last[r]  = src_q[r][0].last;
      end else begin
        req_valid[r] = 1'b0;
        req_data[r]  = '0;
        req_last[r]  = 1'b0;
      end
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, then retire accepted beats.
  task automatic tick();
    @(negedge clk);
    ready_seen     = req_ready;
    fire_seen      = req_valid & req_ready;
    out_valid_seen = out_valid;
    fire5_seen     = valid5 & ready5;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (fire_seen[r]) void'(src_q[r].pop_front());
    end
    drive();
  endtask

  always @(negedge clk) begin
    if (!arst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got index %0d data %0h, expected no beat", out_index, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_index", 64'(out_index), 64'(mon_e.idx));
        check("beat_data",  out_data,       mon_e.data);
        check("beat_last",  64'(out_last),  64'(mon_e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_order [9];
    rr_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    arst       = 1'b1;
    out_ready  = 1'b1;
    pause      = '0;
    valid5     = '0;
    last5      = '1;
    out_ready5 = 1'b1;
    for (int r = 0; r < N5; r++) data5[r] = DW5'(r + 16);
    drive();
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_ready",     64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Reset mid-packet with a beat buffered.
    load(3, 3);
    exp_beat(3, 0, 1'b0);
    drive();
    tick();
    tick();
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    arst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,        64'd0);
    check("rst_out_index", 64'(out_index),  64'd0);
    check("rst_out_last",  64'(out_last),   64'd0);
    check("rst_ready",     64'(req_ready),  64'd0);
    for (int r = 0; r < N; r++) src_q[r].delete();
    drive();
    @(posedge clk);
    #1;
    load(0, 1);
    load(7, 1);
    exp_beat(0, 0, 1'b1);
    exp_beat(7, 0, 1'b1);
    drive();
    arst = 1'b0;
    tick();
    check("first_grant_after_reset", 64'(fire_seen), 64'h01);
    tick();
    check("second_grant_after_reset", 64'(fire_seen), 64'h80);

    // Round-robin over single-beat packets, requester 0 twice.
    for (int r = 0; r < N; r++) load(r, 1);
    load(0, 1);
    for (int i = 0; i < 9; i++) exp_beat(rr_order[i], 0, 1'b1);
    drive();
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_grant", 64'(fire_seen), 64'(8'(1) << rr_order[i]));
    end

    // Lock: requester 3 owns the port for 4 beats while 1 and 5 wait.
    load(3, 4);
    for (int b = 0; b < 4; b++) exp_beat(3, b, b == 3);
    drive();
    tick();
    check("lock_first", 64'(fire_seen), 64'h08);
    load(1, 1);
    load(5, 1);
    exp_beat(5, 0, 1'b1);
    exp_beat(1, 0, 1'b1);
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lock_owner_grant", 64'(fire_seen), 64'h08);
      check("lock_others_not_ready", 64'(ready_seen & 8'h22), 64'd0);
    end
    tick();
    check("after_lock_grant5", 64'(fire_seen), 64'h20);
    tick();
    check("after_lock_grant1", 64'(fire_seen), 64'h02);

    // Locked owner 2 idles for 3 cycles while 6 waits.
    load(2, 4);
    load(6, 1);
    for (int b = 0; b < 4; b++) exp_beat(2, b, b == 3);
    exp_beat(6, 0, 1'b1);
    drive();
    tick();
    check("idle_owner_beat0", 64'(fire_seen), 64'h04);
    tick();
    check("idle_owner_beat1", 64'(fire_seen), 64'h04);
    pause[2] = 1'b1;
    drive();
    for (int g = 0; g < 3; g++) begin
      tick();
      check("gap_no_grant_6", 64'(ready_seen[6]), 64'd0);
      if (g >= 1) check("gap_out_valid_low", 64'(out_valid_seen), 64'd0);
    end
    pause[2] = 1'b0;
    drive();
    tick();
    check("idle_owner_beat2", 64'(fire_seen), 64'h04);
    tick();
    check("idle_owner_beat3", 64'(fire_seen), 64'h04);
    tick();
    check("after_idle_grant6", 64'(fire_seen), 64'h40);

    // Backpressure: output stalls with beat from 4 held, 5 waiting.
    load(4, 1);
    load(5, 1);
    exp_beat(4, 0, 1'b1);
    exp_beat(5, 0, 1'b1);
    drive();
    tick();
    check("bp_first_grant", 64'(fire_seen), 64'h10);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready_low", 64'(ready_seen), 64'd0);
      check("bp_out_valid", 64'(out_valid_seen), 64'd1);
      check("bp_data_held", out_data, dat(4, 0));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_accept", 64'(fire_seen), 64'h20);
    tick();

    // Non-power-of-two: pointer wraps 4 -> 0.
    valid5 = 5'b00100;
    tick();
    check("np2_grant2", 64'(fire5_seen), 64'h04);
    check("np2_index2", 64'(out_index5), 64'd2);
    valid5 = 5'b10000;
    tick();
    check("np2_grant4", 64'(fire5_seen), 64'h10);
    check("np2_index4", 64'(out_index5), 64'd4);
    check("np2_data4",  64'(out_data5),  64'd20);
    valid5 = 5'b11111;
    tick();
    check("np2_wrap_grant0", 64'(fire5_seen), 64'h01);
    check("np2_index0", 64'(out_index5), 64'd0);
    tick();
    check("np2_next_grant1", 64'(fire5_seen), 64'h02);
    valid5 = '0;

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
